mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Request/grant/read-data bundle for both requesters plus RAM port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic        lock0, lock1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        m_read, m_write;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        input  m_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output m_read, m_write, m_addr, m_wdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        output m_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  m_read, m_write, m_addr, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port single-RAM arbiter with bounded lock ownership and
//            1-cycle registered reads. Define MEM_ARB_RR_EN for round-robin
//            ties in IDLE; otherwise port 0 wins every tie.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] c_max_lock     = 4'(MAX_LOCK);
    localparam logic       c_lock_allowed = (MAX_LOCK > 1);

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next, w_cnt_inc;
    logic        w_gnt0, w_gnt1, w_tie_to1;
    logic        r_rvalid0, r_rvalid1;
    logic [31:0] r_rdata0, r_rdata1;

    assign w_cnt_inc = r_cnt + 4'd1;

`ifdef MEM_ARB_RR_EN
    logic r_last_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt0) begin
            r_last_gnt <= 1'b0;
        end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
        end
    end

    assign w_tie_to1 = ~r_last_gnt;
`else
    assign w_tie_to1 = 1'b0;
`endif

    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!reset) begin
            if (r_state == OWN0 && bus.req0) begin
                w_gnt0     = 1'b1;
                w_cnt_next = w_cnt_inc;
                if (!bus.lock0 || w_cnt_inc == c_max_lock) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 4'd0;
                end
            end else if (r_state == OWN1 && bus.req1) begin
                w_gnt1     = 1'b1;
                w_cnt_next = w_cnt_inc;
                if (!bus.lock1 || w_cnt_inc == c_max_lock) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 4'd0;
                end
            end else begin
                // Fresh arbitration, also taken the same cycle an owner lets go
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
                if (bus.req0 && !(bus.req1 && w_tie_to1)) begin
                    w_gnt0 = 1'b1;
                end else if (bus.req1) begin
                    w_gnt1 = 1'b1;
                end
                if (c_lock_allowed && w_gnt0 && bus.lock0) begin
                    w_state_next = OWN0;
                    w_cnt_next   = 4'd1;
                end else if (c_lock_allowed && w_gnt1 && bus.lock1) begin
                    w_state_next = OWN1;
                    w_cnt_next   = 4'd1;
                end
            end
        end
    end

    always_comb begin
        bus.m_read  = 1'b0;
        bus.m_write = 1'b0;
        bus.m_addr  = 32'd0;
        bus.m_wdata = 32'd0;
        if (w_gnt0) begin
            bus.m_read  = ~bus.we0;
            bus.m_write = bus.we0;
            bus.m_addr  = bus.addr0;
            bus.m_wdata = bus.wdata0;
        end else if (w_gnt1) begin
            bus.m_read  = ~bus.we1;
            bus.m_write = bus.we1;
            bus.m_addr  = bus.addr1;
            bus.m_wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= 32'd0;
            r_rdata1  <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
            if (w_gnt0 && !bus.we0) begin
                r_rdata0 <= bus.m_rdata;
            end
            if (w_gnt1 && !bus.we1) begin
                r_rdata1 <= bus.m_rdata;
            end
        end
    end

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    // A pending read pulse is suppressed as soon as reset is applied
    assign bus.rvalid0 = r_rvalid0 & ~reset;
    assign bus.rvalid1 = r_rvalid1 & ~reset;
    assign bus.rdata0  = r_rdata0;
    assign bus.rdata1  = r_rdata1;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and randomized self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram [0:255];
    assign bus.m_rdata = ram[bus.m_addr[7:0]];
    always @(posedge clk) begin
        if (bus.m_write) ram[bus.m_addr[7:0]] <= bus.m_wdata;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 none), beats held, last grant
    int          own  = -1;
    int          beats = 0;
    int          last = 1;
    logic        erv0 = 1'b0, erv1 = 1'b0;
    logic [31:0] erd0 = 32'd0, erd1 = 32'd0;
    logic [31:0] ref_mem [0:255];

    logic [67:0] act_bus;
    logic [65:0] act_rd;
    assign act_bus = {bus.gnt1, bus.gnt0, bus.m_read, bus.m_write, bus.m_addr, bus.m_wdata};
    assign act_rd  = {bus.rvalid1, bus.rvalid0, bus.rdata1, bus.rdata0};

    function automatic int model_win();
        if (reset) return -1;
        if (own == 0 && bus.req0) return 0;
        if (own == 1 && bus.req1) return 1;
        if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_RR_EN
            return (last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (bus.req0) return 0;
        if (bus.req1) return 1;
        return -1;
    endfunction

    function automatic logic [67:0] exp_bus();
        int w = model_win();
        if (w == 0) return {2'b01, ~bus.we0, bus.we0, bus.addr0, bus.wdata0};
        if (w == 1) return {2'b10, ~bus.we1, bus.we1, bus.addr1, bus.wdata1};
        return '0;
    endfunction

    function automatic logic [65:0] exp_rd();
        return {erv1 & ~reset, erv0 & ~reset, erd1, erd0};
    endfunction

    task automatic set_in(input logic rs,
                          input logic r0, input logic w0, input logic l0,
                          input logic [31:0] a0, input logic [31:0] d0,
                          input logic r1, input logic w1, input logic l1,
                          input logic [31:0] a1, input logic [31:0] d1);
        reset = rs;
        bus.req0 = r0; bus.we0 = w0; bus.lock0 = l0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.lock1 = l1; bus.addr1 = a1; bus.wdata1 = d1;
        #1;
    endtask

    // Commit this cycle's inputs to the model, then advance one clock
    task automatic step();
        int   w;
        logic lk;
        w = model_win();
        if (reset) begin
            own = -1; beats = 0; last = 1;
            erv0 = 1'b0; erv1 = 1'b0; erd0 = 32'd0; erd1 = 32'd0;
        end else begin
            erv0 = (w == 0) && !bus.we0;
            erv1 = (w == 1) && !bus.we1;
            if (erv0) erd0 = ref_mem[bus.addr0[7:0]];
            if (erv1) erd1 = ref_mem[bus.addr1[7:0]];
            if (w == 0 && bus.we0) ref_mem[bus.addr0[7:0]] = bus.wdata0;
            if (w == 1 && bus.we1) ref_mem[bus.addr1[7:0]] = bus.wdata1;
            if (w >= 0) begin
                lk = (w == 0) ? bus.lock0 : bus.lock1;
                if (own == w) begin
                    beats++;
                    if (!lk || beats >= MAX_LOCK) own = -1;
                end else if (lk && MAX_LOCK > 1) begin
                    own = w; beats = 1;
                end else begin
                    own = -1;
                end
                last = w;
            end else begin
                own = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 1, 32'h10, 0, 1, 1, 1, 32'h11, 32'h55);
        checks++;
        if ({bus.gnt1, bus.gnt0, bus.m_read, bus.m_write, bus.m_addr} !== 36'd0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0", {bus.gnt1, bus.gnt0, bus.m_read, bus.m_write, bus.m_addr});
        end
        step();
        step();
        checks++;
        if (act_rd !== 66'd0) begin
            errors++;
            $display("FAIL reset_rd: got %h expected 0", act_rd);
        end
    endtask

    task automatic test_read_basic();
        set_in(0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.m_read, bus.m_write, bus.m_addr} !== {4'b1010, 32'h10}) begin
            errors++;
            $display("FAIL read_grant: got %h expected %h", {bus.gnt0, bus.gnt1, bus.m_read, bus.m_write, bus.m_addr}, {4'b1010, 32'h10});
        end
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.rvalid0, bus.rvalid1, bus.rdata0} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL read_data: got %h expected %h", {bus.rvalid0, bus.rvalid1, bus.rdata0}, {2'b10, 32'hDEADBEEF});
        end
        step();
        checks++;
        if ({bus.rvalid0, bus.rdata0} !== {1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL read_hold: got %h expected %h", {bus.rvalid0, bus.rdata0}, {1'b0, 32'hDEADBEEF});
        end
    endtask

    task automatic test_tie();
        int exp_g;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 0, 32'h40 + i, 0, 1, 0, 0, 32'h50 + i, 0);
`ifdef MEM_ARB_RR_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            checks++;
            if ({bus.gnt1, bus.gnt0} !== ((exp_g == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL tie_seq[%0d]: got gnt1/gnt0=%b expected port %0d", i, {bus.gnt1, bus.gnt0}, exp_g);
            end
            step();
        end
    endtask

    task automatic test_lock();
        int exp_g [6];
`ifdef MEM_ARB_RR_EN
        exp_g = '{1, 1, 1, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1, 0, 0};
`endif
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            set_in(0, (i != 0), 0, 0, 32'h10, 0, 1, 1, 1, 32'h30 + i, 32'hA000 + i);
            checks++;
            if ({bus.gnt1, bus.gnt0} !== ((exp_g[i] == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL lock_seq[%0d]: got gnt1/gnt0=%b expected port %0d", i, {bus.gnt1, bus.gnt0}, exp_g[i]);
            end
            step();
        end
    endtask

    task automatic test_own_drop();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 1, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 1, 0, 1, 32'h11, 0, 1, 1, 0, 32'h60, 32'h77);
        checks++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
            errors++;
            $display("FAIL own_block: got gnt1/gnt0=%b expected 01", {bus.gnt1, bus.gnt0});
        end
        step();
        set_in(0, 0, 0, 1, 32'h12, 0, 1, 1, 0, 32'h60, 32'h77);
        checks++;
        if ({bus.gnt1, bus.gnt0, bus.m_write, bus.m_addr} !== {3'b101, 32'h60}) begin
            errors++;
            $display("FAIL own_drop: got %h expected %h", {bus.gnt1, bus.gnt0, bus.m_write, bus.m_addr}, {3'b101, 32'h60});
        end
        step();
        set_in(0, 1, 0, 0, 32'h13, 0, 1, 0, 0, 32'h61, 0);
        checks++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
            errors++;
            $display("FAIL own_idle_tie: got gnt1/gnt0=%b expected 01", {bus.gnt1, bus.gnt0});
        end
        step();
    endtask

    task automatic test_reset_mid();
        set_in(0, 1, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        step();
        set_in(1, 1, 0, 1, 32'h10, 0, 1, 0, 0, 32'h11, 0);
        checks++;
        if ({bus.gnt1, bus.gnt0, bus.rvalid0} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_rvalid: got gnt1/gnt0/rvalid0=%b expected 000", {bus.gnt1, bus.gnt0, bus.rvalid0});
        end
        step();
        set_in(0, 1, 0, 0, 32'h10, 0, 1, 0, 0, 32'h11, 0);
        checks++;
        if ({bus.gnt1, bus.gnt0, bus.rvalid0} !== 3'b010) begin
            errors++;
            $display("FAIL rst_first_tie: got gnt1/gnt0/rvalid0=%b expected 010", {bus.gnt1, bus.gnt0, bus.rvalid0});
        end
        step();
    endtask

    task automatic test_write_read();
        set_in(0, 1, 1, 0, 32'h20, 32'h12345678, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.gnt0, bus.m_write, bus.m_read, bus.m_wdata} !== {3'b110, 32'h12345678}) begin
            errors++;
            $display("FAIL wr_grant: got %h expected %h", {bus.gnt0, bus.m_write, bus.m_read, bus.m_wdata}, {3'b110, 32'h12345678});
        end
        step();
        checks++;
        if (bus.rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_rvalid: got %b expected 0", bus.rvalid0);
        end
        set_in(0, 1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.rvalid0, bus.rdata0} !== {1'b1, 32'h12345678}) begin
            errors++;
            $display("FAIL wr_readback: got %h expected %h", {bus.rvalid0, bus.rdata0}, {1'b1, 32'h12345678});
        end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            set_in(($urandom_range(0, 39) == 0),
                   ($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom_range(0, 1),
                   32'($urandom_range(0, 63)), $urandom,
                   ($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom_range(0, 1),
                   32'($urandom_range(0, 63)), $urandom);
            checks++;
            if (act_bus !== exp_bus()) begin
                errors++;
                $display("FAIL rand_bus[%0d]: got %h expected %h", n, act_bus, exp_bus());
            end
            checks++;
            if (act_rd !== exp_rd()) begin
                errors++;
                $display("FAIL rand_rd[%0d]: got %h expected %h", n, act_rd, exp_rd());
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'hA5000000 | 32'(i);
            ref_mem[i] = 32'hA5000000 | 32'(i);
        end
        ram[16]     = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;

        test_reset();
        test_read_basic();
        test_tie();
        test_lock();
        test_own_drop();
        test_reset_mid();
        test_write_read();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
